// File: rtl/fp_round_pipe.sv
// rtl/fp_round_pipe.sv - two-stage IEEE-754 rounding pipeline with valid/ready handshake
module fp_round_pipe #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W+2:0] in_mant,
  input  logic [1:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [MANT_W-1:0] out_mant,
  output logic              out_inexact,
  output logic              out_overflow
);

  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [EXP_W-1:0] EXP_ONE = {{(EXP_W-1){1'b0}}, 1'b1};

  logic              s1_valid_q;
  logic [MANT_W:0]   s1_sum_q, s1_sum_d;
  logic              s1_sign_q;
  logic [EXP_W-1:0]  s1_exp_q;
  logic              s1_inexact_q, s1_inexact_d;
  logic              s1_special_q, s1_special_d;

  logic              out_valid_q;
  logic              out_sign_q;
  logic [EXP_W-1:0]  out_exp_q, out_exp_d;
  logic [MANT_W-1:0] out_mant_q, out_mant_d;
  logic              out_inexact_q, out_inexact_d;
  logic              out_overflow_q, out_overflow_d;

  logic s1_accept, s2_accept;
  logic lsb, g, r, s, grs_any, inc;

  assign s2_accept = ~out_valid_q | out_ready;
  assign s1_accept = ~s1_valid_q | s2_accept;
  assign in_ready  = s1_accept;

  assign lsb     = in_mant[3];
  assign g       = in_mant[2];
  assign r       = in_mant[1];
  assign s       = in_mant[0];
  assign grs_any = g | r | s;

  assign s1_special_d = (in_exp == EXP_MAX);
  assign s1_inexact_d = grs_any & ~s1_special_d;

  always_comb begin
    inc = 1'b0;
    unique case (in_mode)
      2'b00:   inc = g & (r | s | lsb);
      2'b01:   inc = 1'b0;
      2'b10:   inc = ~in_sign & grs_any;
      default: inc = in_sign & grs_any;
    endcase
    if (s1_special_d) inc = 1'b0;
  end

  assign s1_sum_d = {1'b0, in_mant[MANT_W+2:3]} + {{MANT_W{1'b0}}, inc};

  // A carry-out leaves exactly 1.000..0 in sum, so shifting right by one renormalises.
  always_comb begin
    out_exp_d      = s1_exp_q;
    out_mant_d     = s1_sum_q[MANT_W-1:0];
    out_inexact_d  = s1_inexact_q;
    out_overflow_d = 1'b0;
    if (s1_sum_q[MANT_W] && !s1_special_q) begin
      out_exp_d  = s1_exp_q + EXP_ONE;
      out_mant_d = s1_sum_q[MANT_W:1];
      if (out_exp_d == EXP_MAX) begin
        out_mant_d     = '0;
        out_overflow_d = 1'b1;
        out_inexact_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_sum_q     <= '0;
      s1_sign_q    <= 1'b0;
      s1_exp_q     <= '0;
      s1_inexact_q <= 1'b0;
      s1_special_q <= 1'b0;
    end else if (s1_accept) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_sum_q     <= s1_sum_d;
        s1_sign_q    <= in_sign;
        s1_exp_q     <= in_exp;
        s1_inexact_q <= s1_inexact_d;
        s1_special_q <= s1_special_d;
      end
    end
  end

  // Output registers only move when the consumer can take them, which keeps them stable under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q    <= 1'b0;
      out_sign_q     <= 1'b0;
      out_exp_q      <= '0;
      out_mant_q     <= '0;
      out_inexact_q  <= 1'b0;
      out_overflow_q <= 1'b0;
    end else if (s2_accept) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_sign_q     <= s1_sign_q;
        out_exp_q      <= out_exp_d;
        out_mant_q     <= out_mant_d;
        out_inexact_q  <= out_inexact_d;
        out_overflow_q <= out_overflow_d;
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign out_sign     = out_sign_q;
  assign out_exp      = out_exp_q;
  assign out_mant     = out_mant_q;
  assign out_inexact  = out_inexact_q;
  assign out_overflow = out_overflow_q;

endmodule

// File: tb/tb_fp_round_pipe.sv
// tb/tb_fp_round_pipe.sv - self-checking bench for fp_round_pipe
module tb_fp_round_pipe;

  localparam int MANT_W = 24;
  localparam int EXP_W  = 8;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
    logic              inx;
    logic              ovf;
  } res_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_sign = 1'b0;
  logic [EXP_W-1:0]  in_exp = '0;
  logic [MANT_W+2:0] in_mant = '0;
  logic [1:0]        in_mode = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              out_sign;
  logic [EXP_W-1:0]  out_exp;
  logic [MANT_W-1:0] out_mant;
  logic              out_inexact;
  logic              out_overflow;

  fp_round_pipe #(.MANT_W(MANT_W), .EXP_W(EXP_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exp(out_exp), .out_mant(out_mant),
    .out_inexact(out_inexact), .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   nrecv = 0;
  res_t sb[$];
  bit   stall_q = 1'b0;
  res_t hold;
  bit   acc;
  bit   ir;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic res_t mk(input logic sg, input logic [EXP_W-1:0] e,
                              input logic [MANT_W-1:0] m, input logic inx, input logic ovf);
    res_t t;
    t.sign = sg; t.exp = e; t.mant = m; t.inx = inx; t.ovf = ovf;
    return t;
  endfunction

  // Rounding from the arithmetic meaning: the 3 dropped bits are a fraction of grs/8 ulp.
  function automatic res_t model(input logic sg, input logic [EXP_W-1:0] e,
                                 input logic [MANT_W+2:0] m, input logic [1:0] md);
    res_t t;
    longint unsigned mant, rounded;
    int grs;
    bit up;
    mant = 64'(m[MANT_W+2:3]);
    grs  = int'(m[2:0]);
    t.sign = sg; t.exp = e; t.ovf = 1'b0;
    if (int'(e) == (1 << EXP_W) - 1) begin
      t.mant = MANT_W'(mant); t.inx = 1'b0;
      return t;
    end
    t.inx = (grs != 0);
    case (md)
      2'd0:    up = (grs > 4) || (grs == 4 && (mant % 2) == 1);
      2'd1:    up = 1'b0;
      2'd2:    up = !sg && grs != 0;
      default: up = sg && grs != 0;
    endcase
    rounded = mant + (up ? 64'd1 : 64'd0);
    if (rounded == (64'd1 << MANT_W)) begin
      t.mant = MANT_W'(rounded / 2);
      if (int'(e) + 1 == (1 << EXP_W) - 1) begin
        t.exp = '1; t.mant = '0; t.ovf = 1'b1; t.inx = 1'b1;
      end else begin
        t.exp = EXP_W'(int'(e) + 1);
      end
    end else begin
      t.mant = MANT_W'(rounded);
    end
    return t;
  endfunction

  task automatic cyc(input bit v, input logic sg, input logic [EXP_W-1:0] e,
                     input logic [MANT_W+2:0] m, input logic [1:0] md, input bit ordy,
                     input bit use_want, input res_t want);
    res_t t;
    in_valid = v; in_sign = sg; in_exp = e; in_mant = m; in_mode = md; out_ready = ordy;
    #1;
    if (stall_q) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_data", 64'({out_sign, out_exp, out_mant, out_inexact, out_overflow}), 64'(hold));
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 64'(out_valid), 64'd0);
      end else begin
        t = sb.pop_front();
        chk("out_sign", 64'(out_sign), 64'(t.sign));
        chk("out_exp", 64'(out_exp), 64'(t.exp));
        chk("out_mant", 64'(out_mant), 64'(t.mant));
        chk("out_inexact", 64'(out_inexact), 64'(t.inx));
        chk("out_overflow", 64'(out_overflow), 64'(t.ovf));
        nrecv++;
      end
    end
    stall_q = out_valid && !out_ready;
    hold = mk(out_sign, out_exp, out_mant, out_inexact, out_overflow);
    ir  = in_ready;
    acc = v && in_ready;
    if (acc) sb.push_back(use_want ? want : model(sg, e, m, md));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit ordy);
    cyc(1'b0, 1'b0, '0, '0, 2'd0, ordy, 1'b0, '0);
  endtask

  task automatic send(input logic sg, input logic [EXP_W-1:0] e, input logic [MANT_W-1:0] m,
                      input logic [2:0] grs, input logic [1:0] md, input res_t want);
    int n;
    n = 0;
    do begin
      cyc(1'b1, sg, e, {m, grs}, md, 1'b1, 1'b1, want);
      n++;
    end while (!acc && n < 20);
    if (!acc) chk("send_timeout", 64'(in_ready), 64'd1);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() > 0 && n < 40) begin
      idle(1'b1);
      n++;
    end
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  task automatic latency(input string tag);
    send(1'b0, 8'h80, 24'h800001, 3'b100, 2'd0, mk(1'b0, 8'h80, 24'h800002, 1'b1, 1'b0));
    chk({tag, "_lat1"}, 64'(out_valid), 64'd0);
    idle(1'b1);
    chk({tag, "_lat2"}, 64'(out_valid), 64'd1);
    drain({tag, "_drain"});
  endtask

  initial begin
    int k, r0, r1;
    bit saw_block;
    logic [EXP_W-1:0]  e;
    logic [MANT_W-1:0] m;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'({out_sign, out_exp, out_mant, out_inexact, out_overflow}), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    latency("first");

    send(1'b0, 8'h80, 24'h800001, 3'b100, 2'd0, mk(1'b0, 8'h80, 24'h800002, 1'b1, 1'b0));
    send(1'b0, 8'h80, 24'h800002, 3'b100, 2'd0, mk(1'b0, 8'h80, 24'h800002, 1'b1, 1'b0));
    send(1'b0, 8'h80, 24'h800002, 3'b000, 2'd0, mk(1'b0, 8'h80, 24'h800002, 1'b0, 1'b0));
    send(1'b0, 8'h80, 24'h800000, 3'b001, 2'd2, mk(1'b0, 8'h80, 24'h800001, 1'b1, 1'b0));
    send(1'b0, 8'h80, 24'h800000, 3'b001, 2'd3, mk(1'b0, 8'h80, 24'h800000, 1'b1, 1'b0));
    send(1'b0, 8'h80, 24'h800000, 3'b001, 2'd1, mk(1'b0, 8'h80, 24'h800000, 1'b1, 1'b0));
    send(1'b0, 8'h80, 24'h800000, 3'b001, 2'd0, mk(1'b0, 8'h80, 24'h800000, 1'b1, 1'b0));
    send(1'b1, 8'h80, 24'h800000, 3'b001, 2'd3, mk(1'b1, 8'h80, 24'h800001, 1'b1, 1'b0));
    send(1'b1, 8'h80, 24'h800000, 3'b001, 2'd2, mk(1'b1, 8'h80, 24'h800000, 1'b1, 1'b0));
    send(1'b0, 8'h7E, 24'hFFFFFF, 3'b110, 2'd0, mk(1'b0, 8'h7F, 24'h800000, 1'b1, 1'b0));
    send(1'b0, 8'hFE, 24'hFFFFFF, 3'b110, 2'd0, mk(1'b0, 8'hFF, 24'h000000, 1'b1, 1'b1));
    send(1'b0, 8'hFF, 24'hC00000, 3'b111, 2'd2, mk(1'b0, 8'hFF, 24'hC00000, 1'b0, 1'b0));
    send(1'b1, 8'h00, 24'h000000, 3'b000, 2'd3, mk(1'b1, 8'h00, 24'h000000, 1'b0, 1'b0));
    drain("directed_drain");

    k = 0; saw_block = 1'b0; r0 = nrecv;
    for (int i = 1; i <= 14; i++) begin
      m = {1'b1, 23'(k * 24'h012345)};
      cyc(k < 5, 1'b0, 8'h40, {m, 3'(k + 3)}, 2'(k), !(i >= 2 && i <= 5), 1'b0, '0);
      if (k < 5 && !ir) saw_block = 1'b1;
      if (acc) k++;
    end
    chk("bp_in_ready_dropped", 64'(saw_block), 64'd1);
    chk("bp_all_accepted", 64'(k), 64'd5);
    drain("bp_drain");
    chk("bp_recv_count", 64'(nrecv - r0), 64'd5);

    send(1'b0, 8'h10, 24'h900000, 3'b101, 2'd0, mk(1'b0, 8'h10, 24'h900001, 1'b1, 1'b0));
    send(1'b0, 8'h11, 24'h900000, 3'b011, 2'd0, mk(1'b0, 8'h11, 24'h900000, 1'b1, 1'b0));
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_data", 64'({out_sign, out_exp, out_mant, out_inexact, out_overflow}), 64'd0);
    sb.delete();
    stall_q = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    r1 = nrecv;
    idle(1'b1);
    idle(1'b1);
    chk("midrst_silent", 64'(nrecv - r1), 64'd0);
    latency("postrst");

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: e = 8'hFE;
        1: e = 8'hFF;
        default: e = 8'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0: m = 24'hFFFFFF;
        1: m = 24'h000000;
        default: m = {1'b1, 23'($urandom)};
      endcase
      cyc($urandom_range(0, 3) != 0, 1'($urandom), e, {m, 3'($urandom)}, 2'($urandom),
          $urandom_range(0, 2) != 0, 1'b0, '0);
    end
    drain("rand_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_round_pipe.md
# fp_round_pipe

Parametrised, pipelined IEEE-754 rounding stage for the floating-point add/sub datapath. It takes a normalised mantissa with guard/round/sticky bits, sign and exponent, and applies one of four IEEE rounding modes selected per operation. It renormalises on mantissa carry-out, adjusts the exponent, and flags inexact and overflow. It sits between the normaliser and the result packer, and uses a valid/ready handshake so it can stall with the rest of the multi-cycle FPU.

## Interface
- MANT_W, 24: kept mantissa width including hidden bit (24 = single, 53 = double).
- EXP_W, 8: biased exponent width.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  stage can accept the input beat this cycle.
- in_sign  input  1  sign of the operand.
- in_exp  input  EXP_W  biased exponent.
- in_mant  input  MANT_W+3  {mantissa[MANT_W-1:0], G, R, S}; MSB is the hidden bit; S is already OR-reduced.
- in_mode  input  2  00 RNE, 01 RTZ, 10 RUP (+inf), 11 RDN (-inf).
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- out_sign  output  1  result sign.
- out_exp  output  EXP_W  result exponent.
- out_mant  output  MANT_W  rounded mantissa.
- out_inexact  output  1  any of G/R/S was set (non-special input).
- out_overflow  output  1  rounding drove the exponent to all-ones.

## Operation
- Let L = in_mant[3], G = in_mant[2], R = in_mant[1], S = in_mant[0]. Then inexact = G|R|S.
- Increment decision:
  - RNE: G & (R|S|L).
  - RTZ: 0.
  - RUP: ~sign & inexact.
  - RDN: sign & inexact.
- Stage 1 computes sum = {1'b0, mant} + inc, which is MANT_W+1 bits. It registers sum, sign, exp, inexact and the special flag.
- Stage 2 handles carry-out (sum[MANT_W] = 1):
  - mant = sum[MANT_W:1], which is the hidden bit followed by zeros.
  - exp = exp + 1.
  - If the new exp is all-ones: out_mant = 0 (infinity), overflow = 1, inexact = 1.
- Without carry-out: mant = sum[MANT_W-1:0] and exp is unchanged.
- Special inputs (in_exp all-ones, Inf/NaN):
  - No rounding; pass through with out_mant = in_mant[MANT_W+2:3].
  - inexact = 0, overflow = 0.
- Zero input (mant = 0, GRS = 0) passes through unchanged.
- Sign is never modified.

## Timing
- Two register stages, s1 and s2, each with its own valid bit. Latency is 2 cycles from an accepted input to out_valid when unstalled. Throughput is 1 beat per cycle.
- Ready chain:
  - s2_accept = ~s2_valid | out_ready.
  - s1_accept = ~s1_valid | s2_accept.
  - in_ready = s1_accept, driven combinationally.
- Transfers:
  - A beat is accepted when in_valid & in_ready.
  - A beat leaves when out_valid & out_ready.
  - A simultaneous accept and leave in the same cycle is legal and loses nothing.
- While out_valid & ~out_ready, all out_* signals stay stable. No beat is dropped, duplicated or reordered.
- At most 2 beats are in flight.
- Reset (rst_n low, asynchronous):
  - s1_valid = s2_valid = 0.
  - All out_* data and flags = 0, out_valid = 0.
  - in_ready = 1 in the first cycle after release.
- Reset asserted mid-operation discards in-flight beats immediately. Nothing is emitted after release until new inputs arrive.

## Test plan
- RNE ties, MANT_W = 24, exp = 0x80, sign = 0, mode = 00:
  - mant 0x800001, GRS = 100 -> out_mant 0x800002, exp 0x80, inexact = 1.
  - mant 0x800002, GRS = 100 -> out_mant 0x800002, inexact = 1.
  - mant 0x800002, GRS = 000 -> 0x800002, inexact = 0.
- Mode sweep, mant 0x800000, GRS = 001:
  - sign 0: RUP -> 0x800001; RDN -> 0x800000; RTZ -> 0x800000; RNE -> 0x800000.
  - sign 1: RDN -> 0x800001; RUP -> 0x800000.
  - All cases inexact = 1.
- Carry and overflow, RNE, mant 0xFFFFFF, GRS = 110:
  - exp 0x7E -> mant 0x800000, exp 0x7F, overflow = 0.
  - exp 0xFE -> exp 0xFF, mant 0, overflow = 1, inexact = 1.
- Special pass-through: exp 0xFF, mant 0xC00000, GRS = 111, RUP -> exp 0xFF, mant 0xC00000, inexact = 0, overflow = 0.
- Backpressure: drive 5 back-to-back beats with out_ready low for cycles 2-5.
  - in_ready drops once s1 and s2 are full.
  - Outputs stay stable while stalled.
  - All 5 results emerge in order, with no duplicates, after out_ready returns high.
  - With out_ready high throughout, out_valid first rises 2 cycles after the first accept.
- Reset mid-stream: assert rst_n low for 1 cycle while 2 beats are in flight.
  - out_valid = 0 and outputs = 0 immediately.
  - in_ready = 1 after release.
  - The next single beat returns after exactly 2 cycles.
